// File: rtl/mont_exit_transfer.sv
// Montgomery-domain exit: reduces both point coordinates by R^-1 mod Prime (R = 2^WIDTH).
// Latency WIDTH+2 edges from accepted start to done; starts while busy are ignored.
module mont_exit_transfer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_sig,
  input  logic [WIDTH-1:0] Px_i,
  input  logic [WIDTH-1:0] Py_i,
  input  logic [WIDTH-1:0] Prime,
  output logic [WIDTH-1:0] Px_out,
  output logic [WIDTH-1:0] Py_out,
  output logic             done,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RED, S_FIX} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH:0]   r_tx;
  logic [WIDTH:0]   r_ty;
  logic [WIDTH-1:0] r_p;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_px;
  logic [WIDTH-1:0] r_py;
  logic             r_done;
  logic             r_busy;
  logic [WIDTH-1:0] w_fx;
  logic [WIDTH-1:0] w_fy;
  logic             w_x_ge;
  logic             w_y_ge;

  // One reduction step: make t even by adding p if needed, then halve.
  function automatic logic [WIDTH:0] red_step(input logic [WIDTH:0] t, input logic [WIDTH-1:0] p);
    logic [WIDTH+1:0] s;
    s = {1'b0, t} + (t[0] ? {2'b00, p} : '0);
    return s[WIDTH+1:1];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_sig) w_next = S_RED;
      S_RED:   if (r_cnt == LAST) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_x_ge = (r_tx >= {1'b0, r_p});
  assign w_y_ge = (r_ty >= {1'b0, r_p});
  assign w_fx   = w_x_ge ? (r_tx[WIDTH-1:0] - r_p) : r_tx[WIDTH-1:0];
  assign w_fy   = w_y_ge ? (r_ty[WIDTH-1:0] - r_p) : r_ty[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx   <= '0;
      r_ty   <= '0;
      r_p    <= '0;
      r_cnt  <= '0;
      r_px   <= '0;
      r_py   <= '0;
      r_done <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_sig) begin
            r_tx   <= {1'b0, Px_i};
            r_ty   <= {1'b0, Py_i};
            r_p    <= Prime;
            r_cnt  <= '0;
            r_busy <= 1'b1;
          end
        end
        S_RED: begin
          r_tx  <= red_step(r_tx, r_p);
          r_ty  <= red_step(r_ty, r_p);
          r_cnt <= r_cnt + CW'(1);
        end
        S_FIX: begin
          r_px   <= w_fx;
          r_py   <= w_fy;
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign Px_out = r_px;
  assign Py_out = r_py;
  assign done   = r_done;
  assign busy   = r_busy;

endmodule
